// File: rtl/matmul_sched.sv
// matmul_sched -- shares one matrix-multiply engine between NREQ requesters.
//
// A round-robin arbiter picks one requester and holds its grant for the whole job.
// While the job runs, the block forwards that requester's dims and operands to the
// engine and returns the engine's result words tagged with the owner index.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req[NREQ]                  per-requester job request (level)
//   req_dims_a/b[NREQ*64]      per-requester {rows[63:32], cols[31:0]}, slot i at [i*64 +: 64]
//   req_in_a/b[NREQ*32]        per-requester operand words, slot i at [i*32 +: 32]
//   gnt[NREQ]                  one-hot grant, held for the whole job
//   op_ready                   granted requester must present the next operand pair this cycle
//   eng_start, eng_dims_a/b    one-cycle engine start with the latched dims
//   eng_in_a/b                 operands muxed from the granted requester
//   eng_state, eng_out_c       engine status (IDLE/READ/CALCULATE/WRITE/ERROR) and result word
//   res_valid, res_data, res_id  result word strobe, data and owner
//   done, err                  one-cycle job-complete / job-failed pulses, qualified by res_id
//   busy                       scheduler is not idle
//
// State  | meaning
// S_IDLE  | no job; arbitrate among pending requests
// S_START | eng_start high (or dims rejected -> err)
// S_WAIT  | waiting for the engine to enter READ
// S_RUN   | engine reading operands / calculating
// S_WRITE | collecting result words until count exhausted and engine idle
module matmul_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*64-1:0]        req_dims_a,
    input  logic [NREQ*64-1:0]        req_dims_b,
    input  logic [NREQ*32-1:0]        req_in_a,
    input  logic [NREQ*32-1:0]        req_in_b,
    output logic [NREQ-1:0]           gnt,
    output logic                      op_ready,
    output logic                      eng_start,
    output logic [63:0]               eng_dims_a,
    output logic [63:0]               eng_dims_b,
    output logic [31:0]               eng_in_a,
    output logic [31:0]               eng_in_b,
    input  logic [2:0]                eng_state,
    input  logic [31:0]               eng_out_c,
    output logic                      res_valid,
    output logic [31:0]               res_data,
    output logic [$clog2(NREQ)-1:0]   res_id,
    output logic                      done,
    output logic                      err,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);

    localparam logic [2:0] ENG_IDLE  = 3'd0;
    localparam logic [2:0] ENG_READ  = 3'd1;
    localparam logic [2:0] ENG_WRITE = 3'd3;
    localparam logic [2:0] ENG_ERROR = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RUN,
        S_WRITE
    } state_t;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [31:0]      res_cnt;
    logic [31:0]      tmo_cnt;
    logic             dims_bad;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [NREQ-1:0]  win_onehot;
    logic [63:0]      win_dims_a;
    logic [63:0]      win_dims_b;
    logic [31:0]      size_a;
    logic [31:0]      size_b;
    logic             win_bad;
    logic [IDW-1:0]   rr_next;
    logic             tmo_hit;

    // Round-robin search starting at the slot after the previous winner.
    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!win_found && req[j]) begin
                win_found = 1'b1;
                win_idx   = IDW'(j);
            end
        end
    end

    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
    end

    assign win_dims_a = req_dims_a[int'(win_idx)*64 +: 64];
    assign win_dims_b = req_dims_b[int'(win_idx)*64 +: 64];

    // Element counts are 32-bit truncated products; the engine holds at most 1023 elements.
    assign size_a  = win_dims_a[63:32] * win_dims_a[31:0];
    assign size_b  = win_dims_b[63:32] * win_dims_b[31:0];
    assign win_bad = (win_dims_a[31:0] != win_dims_b[63:32]) ||
                     (size_a >= 32'd1024) || (size_b >= 32'd1024);

    assign rr_next = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    // The counter is loaded with 1 in S_START, so it holds the number of cycles elapsed
    // since eng_start; the job is abandoned on the cycle that count reaches TIMEOUT.
    assign tmo_hit = ((tmo_cnt + 32'd1) == 32'(TIMEOUT));

    assign busy     = (state != S_IDLE);
    assign op_ready = (state == S_RUN) && (eng_state == ENG_READ);
    assign eng_in_a = (|gnt) ? req_in_a[int'(res_id)*32 +: 32] : '0;
    assign eng_in_b = (|gnt) ? req_in_b[int'(res_id)*32 +: 32] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            res_cnt    <= '0;
            tmo_cnt    <= '0;
            dims_bad   <= 1'b0;
            gnt        <= '0;
            eng_start  <= 1'b0;
            eng_dims_a <= '0;
            eng_dims_b <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            res_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        gnt        <= win_onehot;
                        res_id     <= win_idx;
                        eng_dims_a <= win_dims_a;
                        eng_dims_b <= win_dims_b;
                        dims_bad   <= win_bad;
                        eng_start  <= !win_bad;
                        rr_ptr     <= rr_next;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    if (dims_bad) begin
                        err      <= 1'b1;
                        gnt      <= '0;
                        dims_bad <= 1'b0;
                        state    <= S_IDLE;
                    end else begin
                        res_cnt <= eng_dims_a[63:32] * eng_dims_b[31:0];
                        tmo_cnt <= 32'd1;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (tmo_hit || eng_state == ENG_ERROR) begin
                        err   <= 1'b1;
                        gnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                        if (eng_state == ENG_READ) begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (tmo_hit || eng_state == ENG_ERROR) begin
                        err   <= 1'b1;
                        gnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                        if (eng_state == ENG_WRITE) begin
                            state <= S_WRITE;
                            // The first WRITE cycle already carries a result word.
                            if (res_cnt != 32'd0) begin
                                res_valid <= 1'b1;
                                res_data  <= eng_out_c;
                                res_cnt   <= res_cnt - 32'd1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (tmo_hit || eng_state == ENG_ERROR) begin
                        err   <= 1'b1;
                        gnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                        if (eng_state == ENG_WRITE && res_cnt != 32'd0) begin
                            res_valid <= 1'b1;
                            res_data  <= eng_out_c;
                            res_cnt   <= res_cnt - 32'd1;
                        end else if (res_cnt == 32'd0 && eng_state == ENG_IDLE) begin
                            done  <= 1'b1;
                            gnt   <= '0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_sched.sv
module tb_matmul_sched;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [127:0]  req_dims_a;
    logic [127:0]  req_dims_b;
    logic [63:0]   req_in_a;
    logic [63:0]   req_in_b;
    logic [1:0]    gnt;
    logic          op_ready;
    logic          eng_start;
    logic [63:0]   eng_dims_a;
    logic [63:0]   eng_dims_b;
    logic [31:0]   eng_in_a;
    logic [31:0]   eng_in_b;
    logic [2:0]    eng_state;
    logic [31:0]   eng_out_c;
    logic          res_valid;
    logic [31:0]   res_data;
    logic [0:0]    res_id;
    logic          done;
    logic          err;
    logic          busy;

    int total = 0;
    int bad   = 0;

    matmul_sched #(.NREQ(2), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_dims_a (req_dims_a),
        .req_dims_b (req_dims_b),
        .req_in_a   (req_in_a),
        .req_in_b   (req_in_b),
        .gnt        (gnt),
        .op_ready   (op_ready),
        .eng_start  (eng_start),
        .eng_dims_a (eng_dims_a),
        .eng_dims_b (eng_dims_b),
        .eng_in_a   (eng_in_a),
        .eng_in_b   (eng_in_b),
        .eng_state  (eng_state),
        .eng_out_c  (eng_out_c),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_id     (res_id),
        .done       (done),
        .err        (err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] dm(input int rows, input int cols);
        return {32'(rows), 32'(cols)};
    endfunction

    // Called in the cycle eng_start is visible; runs a 1x1 job returning one word.
    task automatic one_word_job(input string tag, input logic [1:0] exp_gnt,
                                input logic [0:0] exp_id, input logic [31:0] word);
        chk({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
        chk({tag, "_start"}, 64'(eng_start), 64'd1);
        eng_state = 3'd1;
        step();
        step();
        chk({tag, "_opready"}, 64'(op_ready), 64'd1);
        eng_state = 3'd3;
        eng_out_c = word;
        step();
        chk({tag, "_rv"}, 64'(res_valid), 64'd1);
        chk({tag, "_rdata"}, 64'(res_data), 64'(word));
        chk({tag, "_rid"}, 64'(res_id), 64'(exp_id));
        eng_state = 3'd0;
        step();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_gnt_rel"}, 64'(gnt), 64'd0);
    endtask

    logic [31:0] exp_c [4];

    initial begin
        exp_c = '{32'd19, 32'd22, 32'd43, 32'd50};
        rst_n      = 1'b0;
        req        = 2'b00;
        req_dims_a = '0;
        req_dims_b = '0;
        req_in_a   = {32'h0000_0033, 32'h0000_0011};
        req_in_b   = {32'h0000_0044, 32'h0000_0022};
        eng_state  = 3'd0;
        eng_out_c  = '0;

        // Reset values
        #3;
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_start", 64'(eng_start), 64'd0);
        chk("rst_opready", 64'(op_ready), 64'd0);
        chk("rst_flags", 64'({res_valid, done, err}), 64'd0);
        #9;
        rst_n = 1'b1;

        // Single 2x2 job on requester 0
        req_dims_a[63:0] = dm(2, 2);
        req_dims_b[63:0] = dm(2, 2);
        req = 2'b01;
        step();
        chk("job_gnt", 64'(gnt), 64'd1);
        chk("job_start", 64'(eng_start), 64'd1);
        chk("job_dims_a", eng_dims_a, dm(2, 2));
        chk("job_busy", 64'(busy), 64'd1);
        req = 2'b00;
        eng_state = 3'd1;
        step();
        chk("job_start_once", 64'(eng_start), 64'd0);
        chk("job_wait_opready", 64'(op_ready), 64'd0);
        step();
        chk("job_opready", 64'(op_ready), 64'd1);
        chk("job_in_a", 64'(eng_in_a), 64'h11);
        chk("job_in_b", 64'(eng_in_b), 64'h22);
        chk("job_gnt_held", 64'(gnt), 64'd1);
        eng_state = 3'd2;
        step();
        chk("job_calc_opready", 64'(op_ready), 64'd0);
        eng_state = 3'd3;
        for (int i = 0; i < 4; i++) begin
            eng_out_c = exp_c[i];
            step();
            chk("job_rv", 64'(res_valid), 64'd1);
            chk("job_rdata", 64'(res_data), 64'(exp_c[i]));
            chk("job_rid", 64'(res_id), 64'd0);
            chk("job_no_done", 64'(done), 64'd0);
        end
        eng_state = 3'd0;
        step();
        chk("job_done", 64'(done), 64'd1);
        chk("job_done_err", 64'(err), 64'd0);
        chk("job_done_rv", 64'(res_valid), 64'd0);
        chk("job_gnt_rel", 64'(gnt), 64'd0);
        step();
        chk("job_done_pulse", 64'(done), 64'd0);
        chk("job_idle", 64'(busy), 64'd0);

        // Contention from reset: alternating grants
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req_dims_a = {dm(1, 1), dm(1, 1)};
        req_dims_b = {dm(1, 1), dm(1, 1)};
        req = 2'b11;
        step();
        one_word_job("rr0", 2'b01, 1'b0, 32'd7);
        step();
        one_word_job("rr1", 2'b10, 1'b1, 32'd9);
        step();
        chk("rr2_gnt", 64'(gnt), 64'd1);

        // Reset in the middle of the READ phase
        eng_state = 3'd1;
        step();
        step();
        chk("mid_opready_pre", 64'(op_ready), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_gnt", 64'(gnt), 64'd0);
        chk("mid_opready", 64'(op_ready), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_in_a", 64'(eng_in_a), 64'd0);
        chk("mid_flags", 64'({eng_start, res_valid, done, err}), 64'd0);
        req = 2'b00;
        eng_state = 3'd0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_no_pulse", 64'({done, err}), 64'd0);
        end

        // Dim mismatch: A 2x3, B 2x2
        req_dims_a[63:0] = dm(2, 3);
        req_dims_b[63:0] = dm(2, 2);
        req = 2'b01;
        step();
        chk("mm_gnt", 64'(gnt), 64'd1);
        chk("mm_no_start", 64'(eng_start), 64'd0);
        req = 2'b00;
        step();
        chk("mm_err", 64'(err), 64'd1);
        chk("mm_err_done", 64'(done), 64'd0);
        chk("mm_gnt_rel", 64'(gnt), 64'd0);
        chk("mm_no_start2", 64'(eng_start), 64'd0);
        step();
        chk("mm_err_pulse", 64'(err), 64'd0);

        // Oversize: A 32x32 has exactly 1024 elements
        req_dims_a[63:0] = dm(32, 32);
        req_dims_b[63:0] = dm(32, 1);
        req = 2'b01;
        step();
        chk("big_no_start", 64'(eng_start), 64'd0);
        req = 2'b00;
        step();
        chk("big_err", 64'(err), 64'd1);

        // 1x1023 * 1023x1 is accepted; engine then reports ERROR
        req_dims_a[63:0] = dm(1, 1023);
        req_dims_b[63:0] = dm(1023, 1);
        req = 2'b01;
        step();
        chk("ee_start", 64'(eng_start), 64'd1);
        req = 2'b00;
        eng_state = 3'd4;
        step();
        chk("ee_no_err_yet", 64'(err), 64'd0);
        step();
        chk("ee_err", 64'(err), 64'd1);
        chk("ee_gnt", 64'(gnt), 64'd0);
        chk("ee_busy", 64'(busy), 64'd0);
        eng_state = 3'd0;
        step();
        chk("ee_err_pulse", 64'(err), 64'd0);

        // Timeout: requester 1, engine stuck in CALCULATE
        req = 2'b10;
        step();
        chk("to_gnt", 64'(gnt), 64'd2);
        chk("to_start", 64'(eng_start), 64'd1);
        req = 2'b00;
        eng_state = 3'd1;
        step();
        chk("to_err_c1", 64'(err), 64'd0);
        step();
        eng_state = 3'd2;
        chk("to_err_c2", 64'(err), 64'd0);
        for (int i = 3; i <= 15; i++) begin
            step();
            chk("to_no_err", 64'(err), 64'd0);
            chk("to_no_rv", 64'(res_valid), 64'd0);
        end
        step();
        chk("to_err", 64'(err), 64'd1);
        chk("to_err_done", 64'(done), 64'd0);
        chk("to_gnt_rel", 64'(gnt), 64'd0);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_rid", 64'(res_id), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
